// File: rtl/vex_wb_sequencer_pkg.sv
// Shared types for the vector writeback sequencer.
// Metadata layout and class ids used by issue and writeback.
package cellrv32_package;

  localparam int VEX_CLS_ALU    = 0;
  localparam int VEX_CLS_MULDIV = 1;
  localparam int VEX_CLS_FP     = 2;

  localparam int VEX_AW    = 5;
  localparam int VEX_LANES = 8;

  typedef struct packed {
    logic [VEX_AW-1:0]    dst;
    logic                 head;
    logic                 tail;
    logic [VEX_LANES-1:0] mask;
  } vex_wb_meta_t;

endpackage

// File: rtl/vex_wb_sequencer_fifo.sv
// In-order metadata queue for one completion class.
// Pointers carry one wrap bit to tell full from empty.
module vex_meta_fifo
  import cellrv32_package::*;
#(
  parameter type T     = vex_wb_meta_t,
  parameter int  DEPTH = 4
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clr_i,
  input  logic push_i,
  input  logic pop_i,
  input  T     din_i,
  output T     dout_o,
  output logic full_o,
  output logic empty_o
);

  localparam int PW = $clog2(DEPTH);

  logic [PW:0] wptr_q, wptr_d;
  logic [PW:0] rptr_q, rptr_d;
  T            mem_q [DEPTH];

  always_comb begin
    wptr_d = wptr_q + (PW+1)'(push_i);
    rptr_d = rptr_q + (PW+1)'(pop_i);
    if (clr_i) begin
      wptr_d = '0;
      rptr_d = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wptr_q <= '0;
      rptr_q <= '0;
    end else begin
      wptr_q <= wptr_d;
      rptr_q <= rptr_d;
    end
  end

  always_ff @(posedge clk) begin
    if (push_i && !clr_i)
      mem_q[wptr_q[PW-1:0]] <= din_i;
  end

  assign dout_o  = mem_q[rptr_q[PW-1:0]];
  assign empty_o = (wptr_q == rptr_q);
  assign full_o  = (wptr_q[PW] != rptr_q[PW]) &&
                   (wptr_q[PW-1:0] == rptr_q[PW-1:0]);

endmodule

// File: rtl/vex_wb_sequencer.sv
// Vector writeback sequencer: per-class metadata queues,
// round-robin completion arbiter and VRF write register.
module vex_wb_sequencer
  import cellrv32_package::*;
#(
  parameter int VECTOR_REGISTERS = 32,
  parameter int VECTOR_LANES     = 8,
  parameter int XLEN             = 32,
  parameter int NUM_CLASSES      = 3,
  parameter int QDEPTH           = 4,
  localparam int AW = $clog2(VECTOR_REGISTERS),
  localparam int L  = VECTOR_LANES,
  localparam int C  = NUM_CLASSES,
  localparam int CW = (C > 1) ? $clog2(C) : 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              flush_i,
  input  logic              issue_valid_i,
  output logic              issue_ready_o,
  input  logic [CW-1:0]     issue_class_i,
  input  logic [AW-1:0]     issue_dst_i,
  input  logic              issue_head_i,
  input  logic              issue_end_i,
  input  logic [L-1:0]      issue_mask_i,
  input  logic [C-1:0]      cmp_valid_i,
  output logic [C-1:0]      cmp_ready_o,
  input  logic [C*L*XLEN-1:0] cmp_data_i,
  input  logic [C*5-1:0]    cmp_fflags_i,
  output logic [L-1:0]      wr_en_o,
  output logic [AW-1:0]     wr_addr_o,
  output logic [L*XLEN-1:0] wr_data_o,
  output logic              wr_head_o,
  output logic              wr_end_o,
  output logic [4:0]        fflags_o,
  output logic              err_o,
  output logic              idle_o
);

  typedef struct packed {
    logic [AW-1:0] dst;
    logic          head;
    logic          tail;
    logic [L-1:0]  mask;
  } meta_t;

  meta_t          din;
  meta_t          dout [C];
  logic [C-1:0]   full, empty, push, grant, elig;
  logic [CW-1:0]  ptr_q, win, win_nxt;
  logic           found, legal, ready_cls, err_set;
  logic [L-1:0]   wr_en_q;
  logic [AW-1:0]  wr_addr_q;
  logic [L*XLEN-1:0] wr_data_q;
  logic           wr_head_q, wr_end_q, err_q, gnt_q;
  logic [4:0]     fflags_q;
  int             idx;

  assign din  = '{dst: issue_dst_i, head: issue_head_i,
                  tail: issue_end_i, mask: issue_mask_i};
  assign elig = cmp_valid_i & ~empty;

  // Search starts at the pointer so the last winner goes to the back.
  always_comb begin
    found = 1'b0;
    win   = '0;
    idx   = 0;
    for (int i = 0; i < C; i++) begin
      idx = (int'(ptr_q) + i) % C;
      if (!found && elig[idx]) begin
        found = 1'b1;
        win   = CW'(idx);
      end
    end
    win_nxt = (int'(win) == C - 1) ? '0 : win + CW'(1);
  end

  always_comb begin
    legal     = 32'(issue_class_i) < 32'(C);
    ready_cls = 1'b0;
    for (int c = 0; c < C; c++) begin
      grant[c] = found && (win == CW'(c));
      if (issue_class_i == CW'(c))
        ready_cls = ~full[c] | grant[c];
    end
    issue_ready_o = legal ? (ready_cls & ~flush_i) : 1'b1;
    for (int c = 0; c < C; c++)
      push[c] = issue_valid_i & legal & ~flush_i &
                (issue_class_i == CW'(c)) & (~full[c] | grant[c]);
    err_set = (|(cmp_valid_i & empty)) | (issue_valid_i & ~legal);
  end

  for (genvar g = 0; g < C; g++) begin : g_q
    vex_meta_fifo #(.T(meta_t), .DEPTH(QDEPTH)) u_q (
      .clk    (clk),
      .rst_n  (rst_n),
      .clr_i  (flush_i),
      .push_i (push[g]),
      .pop_i  (grant[g]),
      .din_i  (din),
      .dout_o (dout[g]),
      .full_o (full[g]),
      .empty_o(empty[g])
    );
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      ptr_q     <= '0;
      wr_en_q   <= '0;
      wr_addr_q <= '0;
      wr_data_q <= '0;
      wr_head_q <= 1'b0;
      wr_end_q  <= 1'b0;
      fflags_q  <= '0;
      err_q     <= 1'b0;
      gnt_q     <= 1'b0;
    end else begin
      err_q     <= err_q | err_set;
      gnt_q     <= found & ~flush_i;
      wr_en_q   <= '0;
      wr_head_q <= 1'b0;
      wr_end_q  <= 1'b0;
      if (flush_i)
        ptr_q <= '0;
      else if (found)
        ptr_q <= win_nxt;
      if (found && !flush_i) begin
        wr_en_q   <= dout[win].mask;
        wr_addr_q <= dout[win].dst;
        wr_head_q <= dout[win].head;
        wr_end_q  <= dout[win].tail;
        wr_data_q <= cmp_data_i[int'(win)*L*XLEN +: L*XLEN];
        fflags_q  <= cmp_fflags_i[int'(win)*5 +: 5];
      end
    end
  end

  assign cmp_ready_o = grant;
  assign wr_en_o     = wr_en_q;
  assign wr_addr_o   = wr_addr_q;
  assign wr_data_o   = wr_data_q;
  assign wr_head_o   = wr_head_q;
  assign wr_end_o    = wr_end_q;
  assign fflags_o    = fflags_q;
  assign err_o       = err_q;
  assign idle_o      = (&empty) & ~gnt_q;

endmodule

// File: tb/tb_vex_wb_sequencer.sv
// Bench for vex_wb_sequencer: queue-level reference model,
// directed scenarios and a randomized run.
module tb_vex_wb_sequencer;

  localparam int C  = 3;
  localparam int L  = 8;
  localparam int X  = 32;
  localparam int AW = 5;
  localparam int QD = 4;
  localparam int DW = L * X;

  logic           clk = 1'b0;
  logic           rst_n;
  logic           flush_i;
  logic           issue_valid_i;
  logic           issue_ready_o;
  logic [1:0]     issue_class_i;
  logic [AW-1:0]  issue_dst_i;
  logic           issue_head_i;
  logic           issue_end_i;
  logic [L-1:0]   issue_mask_i;
  logic [C-1:0]   cmp_valid_i;
  logic [C-1:0]   cmp_ready_o;
  logic [C*DW-1:0] cmp_data_i;
  logic [C*5-1:0] cmp_fflags_i;
  logic [L-1:0]   wr_en_o;
  logic [AW-1:0]  wr_addr_o;
  logic [DW-1:0]  wr_data_o;
  logic           wr_head_o;
  logic           wr_end_o;
  logic [4:0]     fflags_o;
  logic           err_o;
  logic           idle_o;

  always #5 clk = ~clk;

  vex_wb_sequencer dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .flush_i      (flush_i),
    .issue_valid_i(issue_valid_i),
    .issue_ready_o(issue_ready_o),
    .issue_class_i(issue_class_i),
    .issue_dst_i  (issue_dst_i),
    .issue_head_i (issue_head_i),
    .issue_end_i  (issue_end_i),
    .issue_mask_i (issue_mask_i),
    .cmp_valid_i  (cmp_valid_i),
    .cmp_ready_o  (cmp_ready_o),
    .cmp_data_i   (cmp_data_i),
    .cmp_fflags_i (cmp_fflags_i),
    .wr_en_o      (wr_en_o),
    .wr_addr_o    (wr_addr_o),
    .wr_data_o    (wr_data_o),
    .wr_head_o    (wr_head_o),
    .wr_end_o     (wr_end_o),
    .fflags_o     (fflags_o),
    .err_o        (err_o),
    .idle_o       (idle_o)
  );

  int checks = 0;
  int errors = 0;

  task automatic chk(string nm, logic [DW-1:0] act, logic [DW-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  typedef struct {
    logic [AW-1:0] dst;
    logic          hd;
    logic          tl;
    logic [L-1:0]  mask;
  } ent_t;

  ent_t          mq [C][$];
  int            rr;
  bit            m_err, m_pg;
  logic [L-1:0]  m_en;
  logic [AW-1:0] m_addr;
  logic [DW-1:0] m_data;
  logic          m_head, m_end;
  logic [4:0]    m_ff;

  task automatic model_reset();
    for (int c = 0; c < C; c++) mq[c].delete();
    rr = 0; m_err = 0; m_pg = 0;
    m_en = '0; m_addr = '0; m_data = '0;
    m_head = 0; m_end = 0; m_ff = '0;
  endtask

  task automatic idle_in();
    flush_i = 0; issue_valid_i = 0; issue_class_i = '0;
    issue_dst_i = '0; issue_head_i = 0; issue_end_i = 0;
    issue_mask_i = '0; cmp_valid_i = '0;
    cmp_data_i = '0; cmp_fflags_i = '0;
  endtask

  task automatic set_issue(int cls, int dst, bit hd, bit tl, logic [L-1:0] mk);
    issue_valid_i = 1; issue_class_i = 2'(cls);
    issue_dst_i = AW'(dst); issue_head_i = hd;
    issue_end_i = tl; issue_mask_i = mk;
  endtask

  task automatic do_reset();
    idle_in();
    rst_n = 0;
    @(posedge clk);
    @(negedge clk);
    rst_n = 1;
    model_reset();
  endtask

  // One clock: compare combinational outputs, advance the model,
  // then compare registered outputs after the edge.
  task automatic cycle();
    int   w;
    int   cls;
    bit   legal, exp_rdy, all_empty;
    logic [C-1:0] exp_cr;
    ent_t e;
    #1;
    cls   = int'(issue_class_i);
    legal = cls < C;
    w = -1;
    for (int i = 0; i < C; i++) begin
      int k;
      k = (rr + i) % C;
      if (w < 0 && cmp_valid_i[k] && mq[k].size() > 0) w = k;
    end
    exp_cr = '0;
    if (w >= 0) exp_cr[w] = 1'b1;
    if (!legal) exp_rdy = 1;
    else exp_rdy = !flush_i && (mq[cls].size() < QD || w == cls);
    all_empty = 1;
    for (int c = 0; c < C; c++) if (mq[c].size() != 0) all_empty = 0;
    chk("issue_ready", DW'(issue_ready_o), DW'(exp_rdy));
    chk("cmp_ready", DW'(cmp_ready_o), DW'(exp_cr));
    chk("idle", DW'(idle_o), DW'(all_empty && !m_pg));
    for (int c = 0; c < C; c++)
      if (cmp_valid_i[c] && mq[c].size() == 0) m_err = 1;
    if (issue_valid_i && !legal) m_err = 1;
    m_en = '0; m_head = 0; m_end = 0;
    if (w >= 0) begin
      e = mq[w].pop_front();
      if (!flush_i) begin
        m_en = e.mask; m_addr = e.dst;
        m_head = e.hd; m_end = e.tl;
        m_data = cmp_data_i[w*DW +: DW];
        m_ff = cmp_fflags_i[w*5 +: 5];
      end
    end
    if (issue_valid_i && legal && exp_rdy) begin
      e.dst = issue_dst_i; e.hd = issue_head_i;
      e.tl = issue_end_i; e.mask = issue_mask_i;
      mq[cls].push_back(e);
    end
    if (flush_i) begin
      for (int c = 0; c < C; c++) mq[c].delete();
      rr = 0;
    end else if (w >= 0) begin
      rr = (w + 1) % C;
    end
    m_pg = (w >= 0) && !flush_i;
    @(posedge clk);
    #1;
    chk("wr_en", DW'(wr_en_o), DW'(m_en));
    chk("wr_addr", DW'(wr_addr_o), DW'(m_addr));
    chk("wr_data", wr_data_o, m_data);
    chk("wr_head", DW'(wr_head_o), DW'(m_head));
    chk("wr_end", DW'(wr_end_o), DW'(m_end));
    chk("fflags", DW'(fflags_o), DW'(m_ff));
    chk("err", DW'(err_o), DW'(m_err));
    @(negedge clk);
  endtask

  initial begin
    rst_n = 0;
    idle_in();
    @(negedge clk);
    do_reset();

    // reset state
    #1;
    chk("rst_wr_en", DW'(wr_en_o), DW'(0));
    chk("rst_err", DW'(err_o), DW'(0));
    chk("rst_issue_ready", DW'(issue_ready_o), DW'(1));
    chk("rst_cmp_ready", DW'(cmp_ready_o), DW'(0));
    chk("rst_idle", DW'(idle_o), DW'(1));
    @(negedge clk);

    // 1: single ALU uop, data = lane index
    set_issue(0, 5, 1, 1, 8'hFF);
    cycle();
    idle_in(); cycle(); cycle();
    cmp_valid_i = 3'b001;
    for (int i = 0; i < L; i++) cmp_data_i[i*X +: X] = X'(i);
    cycle();
    chk("t1_en", DW'(wr_en_o), DW'(8'hFF));
    chk("t1_addr", DW'(wr_addr_o), DW'(5));
    chk("t1_end", DW'(wr_end_o), DW'(1));
    chk("t1_data", wr_data_o,
        256'h00000007_00000006_00000005_00000004_00000003_00000002_00000001_00000000);
    idle_in(); cycle();
    chk("t1_idle", DW'(idle_o), DW'(1));

    // 2: fill class 1, then push+pop while full
    do_reset();
    for (int i = 1; i <= 4; i++) begin
      set_issue(1, i, 1, 1, 8'h0F);
      cycle();
    end
    idle_in();
    issue_class_i = 2'd1; #1;
    chk("t2_full_rdy", DW'(issue_ready_o), DW'(0));
    issue_class_i = 2'd0; #1;
    chk("t2_alu_rdy", DW'(issue_ready_o), DW'(1));
    set_issue(1, 5, 1, 1, 8'h0F);
    cmp_valid_i = 3'b010; #1;
    chk("t2_pushpop_rdy", DW'(issue_ready_o), DW'(1));
    cycle();
    chk("t2_addr", DW'(wr_addr_o), DW'(1));
    idle_in(); issue_class_i = 2'd1; #1;
    chk("t2_still_full", DW'(issue_ready_o), DW'(0));
    cmp_valid_i = 3'b010;
    for (int i = 0; i < 4; i++) cycle();
    chk("t2_last_addr", DW'(wr_addr_o), DW'(5));

    // 3: round-robin across ALU and FP
    do_reset();
    set_issue(0, 7, 1, 1, 8'hFF); cycle();
    set_issue(2, 9, 1, 1, 8'hFF); cycle();
    idle_in();
    cmp_valid_i = 3'b101;
    cycle();
    chk("t3_first", DW'(wr_addr_o), DW'(7));
    cycle();
    chk("t3_second", DW'(wr_addr_o), DW'(9));

    // 4: completion with an empty queue
    do_reset();
    cmp_valid_i = 3'b100; #1;
    chk("t4_no_ready", DW'(cmp_ready_o), DW'(0));
    cycle();
    chk("t4_err", DW'(err_o), DW'(1));
    idle_in(); flush_i = 1; cycle();
    chk("t4_err_flush", DW'(err_o), DW'(1));

    // 5: flush with a grant in the same cycle
    do_reset();
    set_issue(0, 1, 1, 0, 8'hFF); cycle();
    set_issue(0, 2, 0, 1, 8'hFF); cycle();
    set_issue(1, 3, 1, 1, 8'hFF); cycle();
    idle_in(); flush_i = 1; cmp_valid_i = 3'b001;
    cycle();
    chk("t5_en", DW'(wr_en_o), DW'(0));
    chk("t5_idle", DW'(idle_o), DW'(1));
    idle_in();
    set_issue(0, 12, 1, 1, 8'h3C); cycle();
    idle_in(); cmp_valid_i = 3'b001; cycle();
    chk("t5_addr", DW'(wr_addr_o), DW'(12));
    chk("t5_mask", DW'(wr_en_o), DW'(8'h3C));

    // 6: all-zero mask still retires
    do_reset();
    set_issue(2, 3, 1, 1, 8'h00); cycle();
    idle_in(); cmp_valid_i = 3'b100;
    cmp_fflags_i = 15'h5400;
    cycle();
    chk("t6_en", DW'(wr_en_o), DW'(0));
    chk("t6_end", DW'(wr_end_o), DW'(1));
    chk("t6_ff", DW'(fflags_o), DW'(5'h15));

    // randomized traffic
    do_reset();
    for (int n = 0; n < 3000; n++) begin
      issue_valid_i = 1'($urandom_range(0, 1));
      issue_class_i = ($urandom_range(0, 31) == 0) ? 2'd3 : 2'($urandom_range(0, 2));
      issue_dst_i   = AW'($urandom);
      issue_head_i  = 1'($urandom);
      issue_end_i   = 1'($urandom);
      issue_mask_i  = L'($urandom);
      cmp_valid_i   = C'($urandom);
      for (int i = 0; i < C * L; i++) cmp_data_i[i*X +: X] = $urandom;
      cmp_fflags_i  = 15'($urandom);
      flush_i       = ($urandom_range(0, 39) == 0);
      cycle();
      if ($urandom_range(0, 499) == 0) do_reset();
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
